// File: rtl/reconf_axis_pkg.sv
// Shared AXI-Stream egress constants and beat type for the reconfigurable pipeline.
package reconf_axis_pkg;

    localparam int unsigned DATA_W = 1024;
    localparam int unsigned KEEP_W = DATA_W / 8;

    typedef logic [DATA_W-1:0] beat_t;

endpackage : reconf_axis_pkg

// File: rtl/out_axi_fifo.sv
// Synchronous DEPTH x beat FIFO with push/pop, full/empty flags and occupancy level.
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module out_axi_fifo
    import reconf_axis_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  beat_t            push_data_i,
    input  logic             pop_i,
    output beat_t            pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    beat_t             mem_q [DEPTH];
    beat_t             mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push;
    logic              do_pop;

    assign full_o     = (level_q == LVL_W'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Guard against illegal requests so pointers never run past each other.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next-state for pointers and occupancy; pointers wrap since DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Next-state for storage; when full, a push lands in the slot being popped this cycle.
    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: only slots covered by the level are ever read.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule : out_axi_fifo

// File: rtl/out_axi.sv
// Egress adapter: buffers unstallable IPSA header beats and sends each one as a
// single-beat AXI-Stream packet. Beats arriving while all storage is full are dropped
// and counted.
module out_axi
    import reconf_axis_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ipsa_io_en_out,
    input  logic [DATA_W-1:0]            ipsa_io_data_out,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic [KEEP_W-1:0]            m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [CNT_W-1:0]             drop_count,
    output logic                         overflow
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             tvalid_q, tvalid_d;
    beat_t            tdata_q, tdata_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;

    logic             fifo_full;
    logic             fifo_empty;
    beat_t            fifo_head;
    logic             pop;
    logic             push;
    logic             drop;

    // Pop whenever the output register is free or is being emptied by a handshake.
    assign pop  = !fifo_empty && (!tvalid_q || m_axis_tready);
    assign push = ipsa_io_en_out && (!fifo_full || pop);
    assign drop = ipsa_io_en_out && fifo_full && !pop;

    out_axi_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (ipsa_io_data_out),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    // Output register: load on pop, clear valid when a handshake leaves nothing behind.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (pop) begin
            tvalid_d = 1'b1;
            tdata_d  = fifo_head;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_comb begin
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + CNT_W'(1);
            end
        end
    end

    // All top-level state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    // Every beat is a complete single-beat packet with all bytes valid.
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tvalid_q;
    assign m_axis_tkeep  = {KEEP_W{tvalid_q}};
    assign drop_count    = drop_count_q;
    assign overflow      = overflow_q;

endmodule : out_axi

// File: tb/tb_out_axi.sv
// Directed bench for out_axi: single beat, backpressure, overflow, full push+pop,
// mid-operation reset and drop counter saturation.
module tb_out_axi;
    import reconf_axis_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              en = 1'b0;
    beat_t             din = '0;
    logic              tready = 1'b0;

    logic              tvalid, tlast, ovf;
    beat_t             tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [3:0]        level;
    logic [15:0]       drops;

    logic              s_tvalid, s_tlast, s_ovf;
    beat_t             s_tdata;
    logic [KEEP_W-1:0] s_tkeep;
    logic [3:0]        s_level;
    logic [3:0]        s_drops;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    out_axi #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .ipsa_io_en_out   (en),
        .ipsa_io_data_out (din),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready),
        .m_axis_tdata     (tdata),
        .m_axis_tkeep     (tkeep),
        .m_axis_tlast     (tlast),
        .fifo_level       (level),
        .drop_count       (drops),
        .overflow         (ovf)
    );

    out_axi #(.DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clock            (clock),
        .reset            (reset),
        .ipsa_io_en_out   (en),
        .ipsa_io_data_out (din),
        .m_axis_tvalid    (s_tvalid),
        .m_axis_tready    (tready),
        .m_axis_tdata     (s_tdata),
        .m_axis_tkeep     (s_tkeep),
        .m_axis_tlast     (s_tlast),
        .fifo_level       (s_level),
        .drop_count       (s_drops),
        .overflow         (s_ovf)
    );

    function automatic beat_t mk(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {32{w}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        en = 1'b0;
        tready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            din = mk(base + i);
            tick();
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got %0b want 0", tvalid); end
        total++;
        if (tdata !== '0) begin bad++; $display("FAIL rst_tdata got %0h want 0", tdata[63:0]); end
        total++;
        if (level !== 4'd0) begin bad++; $display("FAIL rst_level got %0d want 0", level); end
        total++;
        if (drops !== 16'd0 || ovf !== 1'b0) begin
            bad++; $display("FAIL rst_drop got %0d/%0b want 0/0", drops, ovf);
        end
        total++;
        if (tkeep !== '0 || tlast !== 1'b0) begin
            bad++; $display("FAIL rst_keep_last got %0h/%0b want 0/0", tkeep, tlast);
        end
        total++;
    endtask

    task automatic test_single_beat();
        beat_t a5;
        do_reset();
        tready = 1'b1;
        for (int c = 1; c < 5; c++) tick();
        a5 = {128{8'hA5}};
        en = 1'b1;
        din = a5;
        tick();
        en = 1'b0;
        // cycle 6
        if (tvalid !== 1'b0) begin bad++; $display("FAIL t1_c6_tvalid got %0b want 0", tvalid); end
        total++;
        if (level !== 4'd1) begin bad++; $display("FAIL t1_c6_level got %0d want 1", level); end
        total++;
        tick();
        // cycle 7
        if (tvalid !== 1'b1 || tdata !== a5) begin
            bad++; $display("FAIL t1_c7_beat got %0b/%0h want 1/%0h", tvalid, tdata[63:0], a5[63:0]);
        end
        total++;
        if (tlast !== 1'b1 || tkeep !== {KEEP_W{1'b1}}) begin
            bad++; $display("FAIL t1_c7_last_keep got %0b/%0h want 1/all ones", tlast, tkeep);
        end
        total++;
        if (level !== 4'd0) begin bad++; $display("FAIL t1_c7_level got %0d want 0", level); end
        total++;
        tick();
        if (tvalid !== 1'b0) begin bad++; $display("FAIL t1_c8_tvalid got %0b want 0", tvalid); end
        total++;
    endtask

    task automatic test_backpressure();
        beat_t d0;
        do_reset();
        d0 = mk(100);
        push_n(3, 100);
        if (tvalid !== 1'b1 || tdata !== d0) begin
            bad++; $display("FAIL t2_hold got %0b/%0h want 1/%0h", tvalid, tdata[63:0], d0[63:0]);
        end
        total++;
        if (level !== 4'd2) begin bad++; $display("FAIL t2_level got %0d want 2", level); end
        total++;
        tick();
        if (tvalid !== 1'b1 || tdata !== d0 || level !== 4'd2) begin
            bad++; $display("FAIL t2_stable got %0b/%0h/%0d want 1/%0h/2", tvalid, tdata[63:0], level, d0[63:0]);
        end
        total++;
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat_t exp;
            exp = mk(100 + i);
            if (tvalid !== 1'b1 || tdata !== exp) begin
                bad++; $display("FAIL t2_drain%0d got %0b/%0h want 1/%0h", i, tvalid, tdata[63:0], exp[63:0]);
            end
            total++;
            tick();
        end
        if (tvalid !== 1'b0) begin bad++; $display("FAIL t2_end_tvalid got %0b want 0", tvalid); end
        total++;
    endtask

    task automatic test_overflow();
        do_reset();
        push_n(12, 200);
        if (level !== 4'd8) begin bad++; $display("FAIL t3_level got %0d want 8", level); end
        total++;
        if (drops !== 16'd3) begin bad++; $display("FAIL t3_drops got %0d want 3", drops); end
        total++;
        if (ovf !== 1'b1) begin bad++; $display("FAIL t3_ovf got %0b want 1", ovf); end
        total++;
        tready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            beat_t exp;
            exp = mk(200 + i);
            if (tvalid !== 1'b1 || tdata !== exp) begin
                bad++; $display("FAIL t3_drain%0d got %0b/%0h want 1/%0h", i, tvalid, tdata[63:0], exp[63:0]);
            end
            total++;
            tick();
        end
        if (tvalid !== 1'b0 || level !== 4'd0) begin
            bad++; $display("FAIL t3_empty got %0b/%0d want 0/0", tvalid, level);
        end
        total++;
        if (ovf !== 1'b1 || drops !== 16'd3) begin
            bad++; $display("FAIL t3_sticky got %0b/%0d want 1/3", ovf, drops);
        end
        total++;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        push_n(9, 300);
        if (level !== 4'd8) begin bad++; $display("FAIL t4_full got %0d want 8", level); end
        total++;
        en = 1'b1;
        din = mk(309);
        tready = 1'b1;
        tick();
        en = 1'b0;
        if (level !== 4'd8) begin bad++; $display("FAIL t4_level got %0d want 8", level); end
        total++;
        if (drops !== 16'd0 || ovf !== 1'b0) begin
            bad++; $display("FAIL t4_nodrop got %0d/%0b want 0/0", drops, ovf);
        end
        total++;
        for (int i = 1; i < 10; i++) begin
            beat_t exp;
            exp = mk(300 + i);
            if (tvalid !== 1'b1 || tdata !== exp) begin
                bad++; $display("FAIL t4_drain%0d got %0b/%0h want 1/%0h", i, tvalid, tdata[63:0], exp[63:0]);
            end
            total++;
            tick();
        end
        if (tvalid !== 1'b0) begin bad++; $display("FAIL t4_end got %0b want 0", tvalid); end
        total++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_n(12, 400);
        tready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tready = 1'b0;
        if (level !== 4'd5 || tvalid !== 1'b1) begin
            bad++; $display("FAIL t5_pre got %0d/%0b want 5/1", level, tvalid);
        end
        total++;
        reset = 1'b0;
        en = 1'b1;
        din = mk(499);
        tready = 1'b1;
        tick();
        reset = 1'b1;
        en = 1'b0;
        if (tvalid !== 1'b0 || level !== 4'd0) begin
            bad++; $display("FAIL t5_cleared got %0b/%0d want 0/0", tvalid, level);
        end
        total++;
        if (drops !== 16'd0 || ovf !== 1'b0) begin
            bad++; $display("FAIL t5_drop_clr got %0d/%0b want 0/0", drops, ovf);
        end
        total++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tvalid !== 1'b0) begin bad++; $display("FAIL t5_quiet%0d got %0b want 0", i, tvalid); end
            total++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        push_n(29, 500);
        if (s_drops !== 4'd15) begin bad++; $display("FAIL t6_sat_drops got %0d want 15", s_drops); end
        total++;
        if (s_ovf !== 1'b1) begin bad++; $display("FAIL t6_sat_ovf got %0b want 1", s_ovf); end
        total++;
        if (drops !== 16'd20) begin bad++; $display("FAIL t6_wide_drops got %0d want 20", drops); end
        total++;
        if (s_level !== 4'd8) begin bad++; $display("FAIL t6_level got %0d want 8", s_level); end
        total++;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_out_axi
